// File: rtl/tt_pkg.sv
// Shared state encoding and sizing helpers for the truth-table checker.
package tt_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] APPLY  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Number of input vectors for an n-input function (NVEC = 2^N_IN).
  function automatic int nvec(input int n_in);
    return 1 << n_in;
  endfunction

  // err_cnt must hold 2^N_IN exactly, hence one extra bit.
  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Checker <-> DUT/host bundle: sweep control, vector out, response in, results.
interface truth_table_checker_if #(parameter int N_IN = 4) ();
  logic                   start;
  logic                   f;
  logic [N_IN-1:0]        vec;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_cnt;
  logic [N_IN-1:0]        first_err;
  logic [(1<<N_IN)-1:0]   captured;

  modport master (output start, f,
                  input  vec, busy, done, pass, err_cnt, first_err, captured);
  modport slave  (input  start, f,
                  output vec, busy, done, pass, err_cnt, first_err, captured);
endinterface

// File: rtl/tt_settle_cnt.sv
// Settle-delay counter: counts while enabled, flags when SETTLE-1 is reached.
module tt_settle_cnt #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + 4'd1;
  end

  assign expire = (cnt == 4'(SETTLE - 1));
endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker: sweeps vec, samples f after SETTLE cycles, scores it.
// Build option TT_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int                   N_IN   = 4,
  parameter logic [(1<<N_IN)-1:0] EXP    = '0,
  parameter int                   SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  truth_table_checker_if.slave bus
);
  localparam int NVEC = nvec(N_IN);
  localparam int CW   = cnt_w(N_IN);
`ifdef TT_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  logic [1:0] state;
  logic       expire, mism, last, start_ok, to_done;

  tt_settle_cnt #(.SETTLE(SETTLE)) u_settle (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != APPLY),
    .enable (state == APPLY),
    .expire (expire)
  );

  assign mism     = (bus.f != EXP[bus.vec]);
  assign last     = (bus.vec == N_IN'(NVEC - 1));
  assign start_ok = bus.start && (state == IDLE || state == DONE);
  assign to_done  = last || (STOP_ON_ERR && mism);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.vec       <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_cnt   <= '0;
      bus.first_err <= '1;
      bus.captured  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: if (start_ok) begin
          state         <= APPLY;
          bus.vec       <= '0;
          bus.busy      <= 1'b1;
          bus.pass      <= 1'b0;
          bus.err_cnt   <= '0;
          bus.first_err <= '1;
          bus.captured  <= '0;
        end
        APPLY: if (expire) state <= SAMPLE;
        SAMPLE: begin
          bus.captured[bus.vec] <= bus.f;
          if (mism) begin
            if (bus.err_cnt < CW'(NVEC)) bus.err_cnt <= bus.err_cnt + CW'(1);
            if (bus.err_cnt == '0)        bus.first_err <= bus.vec;
          end
          // pass reflects the count including this final sample
          if (to_done) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= !mism && (bus.err_cnt == '0);
          end else begin
            state   <= APPLY;
            bus.vec <= bus.vec + N_IN'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
